// File: rtl/hex_key_entry.sv
// Push-button hex entry: synchronised, debounced keys feed a nibble shift-register editor.
// The edited value word is consumed by the seven-segment display path.
module hex_key_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DIGITS          = 6
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [3:0]                   sw,
  input  logic                         key_enter_n,
  input  logic                         key_back_n,
  input  logic                         key_clear_n,
  output logic [4*DIGITS-1:0]          value,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         full,
  output logic                         strobe,
  output logic                         reject
);

  localparam int unsigned VW   = 4 * DIGITS;
  localparam int unsigned CNTW = $clog2(DIGITS + 1);
  localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES);

  // Key bit order: [0] enter, [1] back, [2] clear
  logic [2:0]         keys_n;
  logic [2:0]         sync1_q, sync2_q;
  logic [3:0]         sw_s1_q, sw_s2_q;
  logic [2:0]         deb_q, deb_d;
  logic [2:0]         deb_prev_q;
  logic [2:0][CW-1:0] cnt_q, cnt_d;
  logic [2:0]         press;

  logic [VW-1:0]      value_q, value_d;
  logic [CNTW-1:0]    count_q, count_d;
  logic               full_q, full_d;
  logic               strobe_q, strobe_d;
  logic               reject_q, reject_d;

  assign keys_n = {key_clear_n, key_back_n, key_enter_n};
  assign press  = deb_prev_q & ~deb_q;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int k = 0; k < 3; k++) begin
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[k] = sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end
    end
  end

  // Only the highest-priority press acts; losers vanish without a reject.
  always_comb begin
    value_d  = value_q;
    count_d  = count_q;
    strobe_d = 1'b0;
    reject_d = 1'b0;
    if (press[2]) begin
      value_d  = '0;
      count_d  = '0;
      strobe_d = 1'b1;
    end else if (press[1]) begin
      if (count_q == '0) begin
        reject_d = 1'b1;
      end else begin
        value_d  = value_q >> 4;
        count_d  = count_q - CNTW'(1);
        strobe_d = 1'b1;
      end
    end else if (press[0]) begin
      if (count_q == CNTW'(DIGITS)) begin
        reject_d = 1'b1;
      end else begin
        value_d  = (value_q << 4) | VW'(sw_s2_q);
        count_d  = count_q + CNTW'(1);
        strobe_d = 1'b1;
      end
    end
    full_d = (count_d == CNTW'(DIGITS));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      deb_q      <= '1;
      deb_prev_q <= '1;
      cnt_q      <= '0;
      value_q    <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      strobe_q   <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      sync1_q    <= keys_n;
      sync2_q    <= sync1_q;
      sw_s1_q    <= sw;
      sw_s2_q    <= sw_s1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      value_q    <= value_d;
      count_q    <= count_d;
      full_q     <= full_d;
      strobe_q   <= strobe_d;
      reject_q   <= reject_d;
    end
  end

  assign value       = value_q;
  assign digit_count = count_q;
  assign full        = full_q;
  assign strobe      = strobe_q;
  assign reject      = reject_q;

endmodule

// File: tb/tb_hex_key_entry.sv
// Directed bench for hex_key_entry with a short debounce window (4 cycles) and 6 digits.
module tb_hex_key_entry;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  sw = 4'h0;
  logic        key_enter_n = 1'b1;
  logic        key_back_n = 1'b1;
  logic        key_clear_n = 1'b1;
  logic [23:0] value;
  logic [2:0]  digit_count;
  logic        full, strobe, reject;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;
  int reject_cnt = 0;
  int both_cnt = 0;

  hex_key_entry #(.DEBOUNCE_CYCLES(4), .DIGITS(6)) dut (
    .clk(clk), .reset_n(reset_n), .sw(sw),
    .key_enter_n(key_enter_n), .key_back_n(key_back_n), .key_clear_n(key_clear_n),
    .value(value), .digit_count(digit_count), .full(full),
    .strobe(strobe), .reject(reject)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (strobe) strobe_cnt++;
    if (reject) reject_cnt++;
    if (strobe && reject) both_cnt++;
  end

  // keys: [0] enter, [1] back, [2] clear; held 10 cycles then released and settled
  task automatic press(input logic [2:0] keys, input logic [3:0] d);
    @(negedge clk);
    sw = d;
    if (keys[0]) key_enter_n = 1'b0;
    if (keys[1]) key_back_n  = 1'b0;
    if (keys[2]) key_clear_n = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    key_enter_n = 1'b1;
    key_back_n  = 1'b1;
    key_clear_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (value !== 24'h0) begin bad++; $display("FAIL reset_value got=%h want=%h", value, 24'h0); end
    total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", digit_count); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    total++; if ({strobe, reject} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b want=00", {strobe, reject}); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_latency();
    int s0;
    s0 = strobe_cnt;
    @(negedge clk);
    sw = 4'hA;
    key_enter_n = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    total++; if (value !== 24'h0 || strobe !== 1'b0) begin bad++; $display("FAIL latency_early got=%h/%b want=000000/0", value, strobe); end
    @(posedge clk);
    #1;
    total++; if (value !== 24'h00000A) begin bad++; $display("FAIL latency_value got=%h want=00000a", value); end
    total++; if (digit_count !== 3'd1 || strobe !== 1'b1) begin bad++; $display("FAIL latency_count_strobe got=%0d/%b want=1/1", digit_count, strobe); end
    @(posedge clk);
    #1;
    total++; if (strobe !== 1'b0) begin bad++; $display("FAIL latency_strobe_width got=%b want=0", strobe); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    key_enter_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++; if (strobe_cnt - s0 !== 1) begin bad++; $display("FAIL latency_one_event got=%0d want=1", strobe_cnt - s0); end
  endtask

  task automatic test_glitch();
    int s0, r0;
    s0 = strobe_cnt; r0 = reject_cnt;
    @(negedge clk); sw = 4'h5; key_enter_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); key_enter_n = 1'b1;
    @(negedge clk); key_enter_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); key_enter_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    total++; if (strobe_cnt - s0 !== 0) begin bad++; $display("FAIL glitch_strobe got=%0d want=0", strobe_cnt - s0); end
    total++; if (reject_cnt - r0 !== 0) begin bad++; $display("FAIL glitch_reject got=%0d want=0", reject_cnt - r0); end
    total++; if (value !== 24'h00000A || digit_count !== 3'd1) begin bad++; $display("FAIL glitch_value got=%h/%0d want=00000a/1", value, digit_count); end
  endtask

  task automatic test_fill();
    int s0, r0;
    press(3'b100, 4'h0);
    total++; if (value !== 24'h0 || digit_count !== 3'd0) begin bad++; $display("FAIL fill_clear got=%h/%0d want=0/0", value, digit_count); end
    for (int i = 1; i <= 6; i++) begin
      press(3'b001, 4'(i));
      if (i == 5) begin
        total++; if (full !== 1'b0 || digit_count !== 3'd5) begin bad++; $display("FAIL fill_five got=%b/%0d want=0/5", full, digit_count); end
      end
    end
    total++; if (value !== 24'h123456) begin bad++; $display("FAIL fill_value got=%h want=123456", value); end
    total++; if (full !== 1'b1 || digit_count !== 3'd6) begin bad++; $display("FAIL fill_full got=%b/%0d want=1/6", full, digit_count); end
    s0 = strobe_cnt; r0 = reject_cnt;
    press(3'b001, 4'h7);
    total++; if (reject_cnt - r0 !== 1 || strobe_cnt - s0 !== 0) begin bad++; $display("FAIL fill_reject got=r%0d/s%0d want=r1/s0", reject_cnt - r0, strobe_cnt - s0); end
    total++; if (value !== 24'h123456) begin bad++; $display("FAIL fill_unchanged got=%h want=123456", value); end
  endtask

  task automatic test_back_clear();
    int s0, r0;
    press(3'b010, 4'h0);
    press(3'b010, 4'h0);
    total++; if (value !== 24'h001234 || digit_count !== 3'd4 || full !== 1'b0) begin bad++; $display("FAIL back_value got=%h/%0d/%b want=001234/4/0", value, digit_count, full); end
    press(3'b100, 4'h0);
    total++; if (value !== 24'h0 || digit_count !== 3'd0) begin bad++; $display("FAIL back_clear got=%h/%0d want=0/0", value, digit_count); end
    s0 = strobe_cnt; r0 = reject_cnt;
    press(3'b010, 4'h0);
    total++; if (reject_cnt - r0 !== 1 || strobe_cnt - s0 !== 0 || value !== 24'h0) begin bad++; $display("FAIL back_empty got=r%0d/s%0d/%h want=r1/s0/0", reject_cnt - r0, strobe_cnt - s0, value); end
    s0 = strobe_cnt; r0 = reject_cnt;
    press(3'b100, 4'h0);
    total++; if (strobe_cnt - s0 !== 1 || reject_cnt - r0 !== 0) begin bad++; $display("FAIL clear_empty got=s%0d/r%0d want=s1/r0", strobe_cnt - s0, reject_cnt - r0); end
  endtask

  task automatic test_priority();
    int s0, r0;
    press(3'b001, 4'h8);
    press(3'b001, 4'h9);
    total++; if (value !== 24'h000089 || digit_count !== 3'd2) begin bad++; $display("FAIL prio_setup got=%h/%0d want=000089/2", value, digit_count); end
    s0 = strobe_cnt; r0 = reject_cnt;
    press(3'b101, 4'hF);
    total++; if (value !== 24'h0 || digit_count !== 3'd0) begin bad++; $display("FAIL prio_clear_wins got=%h/%0d want=0/0", value, digit_count); end
    total++; if (strobe_cnt - s0 !== 1 || reject_cnt - r0 !== 0) begin bad++; $display("FAIL prio_pulses got=s%0d/r%0d want=s1/r0", strobe_cnt - s0, reject_cnt - r0); end
    s0 = strobe_cnt; r0 = reject_cnt;
    press(3'b011, 4'hC);
    total++; if (value !== 24'h0 || reject_cnt - r0 !== 1 || strobe_cnt - s0 !== 0) begin bad++; $display("FAIL prio_back_wins got=%h/r%0d/s%0d want=0/r1/s0", value, reject_cnt - r0, strobe_cnt - s0); end
  endtask

  task automatic test_reset_mid_debounce();
    press(3'b001, 4'h5);
    total++; if (value !== 24'h000005) begin bad++; $display("FAIL mid_setup got=%h want=000005", value); end
    @(negedge clk);
    sw = 4'h3;
    key_enter_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk);
    #1;
    total++; if (value !== 24'h0 || digit_count !== 3'd0 || full !== 1'b0 || strobe !== 1'b0 || reject !== 1'b0) begin bad++; $display("FAIL mid_reset got=%h/%0d/%b%b%b want=0/0/000", value, digit_count, full, strobe, reject); end
    @(negedge clk); reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    total++; if (value !== 24'h0 || strobe !== 1'b0) begin bad++; $display("FAIL mid_early got=%h/%b want=0/0", value, strobe); end
    @(posedge clk);
    #1;
    total++; if (value !== 24'h000003 || digit_count !== 3'd1 || strobe !== 1'b1) begin bad++; $display("FAIL mid_after got=%h/%0d/%b want=000003/1/1", value, digit_count, strobe); end
    @(negedge clk); key_enter_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_fill();
    test_back_clear();
    test_priority();
    test_reset_mid_debounce();
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL strobe_reject_overlap got=%0d want=0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
